// File: rtl/fp16_pkg.sv
// Shared binary16 format constants, field helpers and the adder's inter-stage record.
package fp16_pkg;

    localparam int          EXP_W   = 5;
    localparam int          MANT_W  = 10;
    localparam int          BIAS    = 15;
    localparam logic [4:0]  EXP_MAX = 5'h1F;

    // Sum keeps {hidden, mant[9:0], guard, round, sticky}; carry is folded in stage 1.
    typedef struct packed {
        logic        sign;
        logic [5:0]  exp;
        logic [13:0] sum;
        logic        is_zero;
        logic        is_inf;
    } stage_t;

    localparam stage_t STAGE_CLEAR = '{sign: 1'b0, exp: 6'd0, sum: 14'd0,
                                       is_zero: 1'b1, is_inf: 1'b0};

    function automatic logic fp_sign(input logic [15:0] x);
        return x[15];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [15:0] x);
        return x[14:10];
    endfunction

    function automatic logic [MANT_W-1:0] fp_mant(input logic [15:0] x);
        return x[9:0];
    endfunction

endpackage

// File: rtl/fp16_lzc.sv
// 14-bit leading-zero counter; an all-zero input reports 14.
module fp16_lzc (
    input  logic [13:0] i_val,
    output logic [3:0]  o_cnt
);

    always_comb begin
        o_cnt = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (i_val[i]) begin
                o_cnt = 4'(13 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_add_pipe.sv
// Two-stage binary16 adder: align/add before the register, normalise/round/pack after it.
module fp16_add_pipe
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_res
);

    stage_t      stage_d, stage_q;

    logic        a_zero, b_zero, a_inf, b_inf, swap, eff_sub, sign_x, sticky;
    logic [14:0] mag_a, mag_b, raw_sum;
    logic [10:0] sig_x, sig_y;
    logic [4:0]  exp_x, exp_y, shamt;
    logic [13:0] ext_x, ext_y, y_full, y_shift, lost_mask;

    always_comb begin
        a_zero  = (fp_exp(i_a) == '0);
        b_zero  = (fp_exp(i_b) == '0);
        a_inf   = (fp_exp(i_a) == EXP_MAX);
        b_inf   = (fp_exp(i_b) == EXP_MAX);
        mag_a   = a_zero ? 15'd0 : i_a[14:0];
        mag_b   = b_zero ? 15'd0 : i_b[14:0];
        swap    = (mag_b > mag_a);
        eff_sub = fp_sign(i_a) ^ fp_sign(i_b);

        sign_x  = swap ? fp_sign(i_b) : fp_sign(i_a);
        exp_x   = swap ? fp_exp(i_b)  : fp_exp(i_a);
        exp_y   = swap ? fp_exp(i_a)  : fp_exp(i_b);
        sig_x   = swap ? (b_zero ? 11'd0 : {1'b1, fp_mant(i_b)})
                       : (a_zero ? 11'd0 : {1'b1, fp_mant(i_a)});
        sig_y   = swap ? (a_zero ? 11'd0 : {1'b1, fp_mant(i_a)})
                       : (b_zero ? 11'd0 : {1'b1, fp_mant(i_b)});

        shamt     = exp_x - exp_y;
        ext_x     = {sig_x, 3'b000};
        y_full    = {sig_y, 3'b000};
        lost_mask = '0;
        if (shamt >= 5'd14) begin
            y_shift = '0;
            sticky  = |sig_y;
        end else begin
            y_shift   = y_full >> shamt;
            lost_mask = (14'd1 << shamt) - 14'd1;
            sticky    = |(y_full & lost_mask);
        end
        ext_y = {y_shift[13:1], y_shift[0] | sticky};

        raw_sum = eff_sub ? ({1'b0, ext_x} - {1'b0, ext_y})
                          : ({1'b0, ext_x} + {1'b0, ext_y});

        stage_d = STAGE_CLEAR;
        if (a_inf || b_inf) begin
            // Opposite-sign infinities resolve to A's sign, which this also covers.
            stage_d.is_zero = 1'b0;
            stage_d.is_inf  = 1'b1;
            stage_d.sign    = a_inf ? fp_sign(i_a) : fp_sign(i_b);
        end else if (raw_sum == '0) begin
            stage_d.sign = eff_sub ? 1'b0 : fp_sign(i_a);
        end else begin
            stage_d.is_zero = 1'b0;
            stage_d.sign    = sign_x;
            if (raw_sum[14]) begin
                stage_d.sum = {raw_sum[14:2], raw_sum[1] | raw_sum[0]};
                stage_d.exp = {1'b0, exp_x} + 6'd1;
            end else begin
                stage_d.sum = raw_sum[13:0];
                stage_d.exp = {1'b0, exp_x};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= STAGE_CLEAR;
        end else begin
            stage_q <= stage_d;
        end
    end

    logic [3:0]        lz;
    logic [13:0]       norm;
    logic              round_up;
    logic [11:0]       sig_rnd;
    logic [9:0]        mant_fin;
    logic signed [7:0] exp_fin;

    fp16_lzc u_lzc (
        .i_val (stage_q.sum),
        .o_cnt (lz)
    );

    always_comb begin
        norm     = stage_q.sum << lz;
        round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
        sig_rnd  = {1'b0, norm[13:3]} + {11'd0, round_up};
        mant_fin = sig_rnd[11] ? sig_rnd[10:1] : sig_rnd[9:0];
        exp_fin  = $signed({2'b00, stage_q.exp}) - $signed({4'b0000, lz})
                 + $signed({7'd0, sig_rnd[11]});

        if (stage_q.is_inf) begin
            o_res = {stage_q.sign, EXP_MAX, 10'd0};
        end else if (stage_q.is_zero || exp_fin <= 8'sd0) begin
            o_res = {stage_q.sign, 15'd0};
        end else if (exp_fin >= 8'sd31) begin
            o_res = {stage_q.sign, EXP_MAX, 10'd0};
        end else begin
            o_res = {stage_q.sign, exp_fin[4:0], mant_fin};
        end
    end

endmodule

// File: tb/tb_fp16_add_pipe.sv
// Bench for fp16_add_pipe: directed vectors, reset sequences and a random sweep vs. a real-valued model.
module tb_fp16_add_pipe;
    import fp16_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_a, i_b, o_res;

    always #5 clk = ~clk;

    fp16_add_pipe dut (
        .clk   (clk),
        .rst   (rst),
        .i_a   (i_a),
        .i_b   (i_b),
        .o_res (o_res)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end else begin
            $display("%s: %h", name, got);
        end
    endtask

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    // Value of a finite operand; subnormals read as zero.
    function automatic real decode(input logic [15:0] x);
        int  be = int'(x[14:10]);
        real v;
        if (be == 0) return 0.0;
        v = (1024.0 + real'(int'(x[9:0]))) * pow2(be - BIAS - 10);
        return x[15] ? -v : v;
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        real s, m, scaled, fl, frac;
        int  e, fi, be;
        logic sgn;
        if (a[14:10] == 5'h1F) return {a[15], 5'h1F, 10'h0};
        if (b[14:10] == 5'h1F) return {b[15], 5'h1F, 10'h0};
        s = decode(a) + decode(b);
        if (s == 0.0) begin
            if (a[14:10] == 5'd0 && b[14:10] == 5'd0 && a[15] && b[15]) return 16'h8000;
            return 16'h0000;
        end
        sgn = (s < 0.0);
        m   = sgn ? -s : s;
        e   = 0;
        while (m >= pow2(e + 1)) e++;
        while (m < pow2(e)) e--;
        scaled = m / pow2(e - 10);
        fl     = $floor(scaled);
        frac   = scaled - fl;
        fi     = $rtoi(fl);
        if (frac > 0.5 || (frac == 0.5 && (fi % 2) == 1)) fi++;
        if (fi == 2048) begin
            fi = 1024;
            e++;
        end
        be = e + BIAS;
        if (be <= 0)  return {sgn, 15'd0};
        if (be >= 31) return {sgn, 5'h1F, 10'h0};
        return {sgn, 5'(be), 10'(fi - 1024)};
    endfunction

    task automatic check_rand(input logic [15:0] a, input logic [15:0] b, input logic [15:0] got);
        logic [15:0] want;
        int          d;
        bit          ok;
        want = ref_add(a, b);
        n_cmp++;
        if (want[14:10] == 5'd0 || want[14:10] == 5'h1F) begin
            ok = (got === want);
        end else begin
            d  = int'(got[14:0]) - int'(want[14:0]);
            if (d < 0) d = -d;
            ok = (got[15] === want[15]) && (d <= 1);
        end
        if (!ok) begin
            n_bad++;
            $display("FAIL rand %h+%h: got %h, expected %h", a, b, got, want);
        end
    endtask

    initial begin
        logic [15:0] ra, rb;

        vecs[0]  = '{16'h3C00, 16'h3C00, 16'h4000};
        vecs[1]  = '{16'h3C00, 16'hBA00, 16'h3400};
        vecs[2]  = '{16'h3C00, 16'hBC00, 16'h0000};
        vecs[3]  = '{16'h7BFF, 16'h7BFF, 16'h7C00};
        vecs[4]  = '{16'hFC00, 16'h3C00, 16'hFC00};
        vecs[5]  = '{16'h7C00, 16'hFC00, 16'h7C00};
        vecs[6]  = '{16'hFC00, 16'h7C00, 16'hFC00};
        vecs[7]  = '{16'h3C00, 16'h0001, 16'h3C00};
        vecs[8]  = '{16'h8000, 16'h8000, 16'h8000};
        vecs[9]  = '{16'h0001, 16'h0001, 16'h0000};
        vecs[10] = '{16'h3C00, 16'h1400, 16'h3C01};
        vecs[11] = '{16'h4000, 16'h0C00, 16'h4000};
        vecs[12] = '{16'h3C00, 16'h1000, 16'h3C00};
        vecs[13] = '{16'h3C01, 16'h1000, 16'h3C02};
        vecs[14] = '{16'h7BFF, 16'h5000, 16'h7C00};
        vecs[15] = '{16'h0400, 16'h8401, 16'h8000};
        vecs[16] = '{16'h0401, 16'h8400, 16'h0000};
        vecs[17] = '{16'h7C01, 16'h3C00, 16'h7C00};
        vecs[18] = '{16'h0000, 16'h8000, 16'h0000};
        vecs[19] = '{16'hC500, 16'h0000, 16'hC500};

        rst = 1'b1;
        i_a = 16'h3C00;
        i_b = 16'h3C00;
        repeat (2) begin
            @(posedge clk); #1;
            check("reset", o_res, 16'h0000);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset", o_res, 16'h4000);

        for (int i = 0; i < 20; i++) begin
            i_a = vecs[i].a;
            i_b = vecs[i].b;
            @(posedge clk); #1;
            check($sformatf("vec%0d %h+%h", i, vecs[i].a, vecs[i].b), o_res, vecs[i].res);
        end

        // Reset arriving with a pair discards it; the next pair flows normally.
        i_a = 16'h4000; i_b = 16'h4000; rst = 1'b1;
        @(posedge clk); #1;
        check("rst_discard", o_res, 16'h0000);
        rst = 1'b0; i_a = 16'h3C00; i_b = 16'hBA00;
        @(posedge clk); #1;
        check("after_rst", o_res, 16'h3400);
        i_a = 16'h4000; i_b = 16'h4000;
        #3;
        check("hold", o_res, 16'h3400);
        @(posedge clk); #1;
        check("next", o_res, 16'h4400);

        for (int i = 0; i < 12000; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'($urandom);
                1:       rb = (ra ^ 16'h8000) ^ 16'($urandom_range(0, 3));
                2:       rb = {1'($urandom), ra[14:10], 10'($urandom)};
                default: rb = {1'($urandom), ra[14:10] - 5'($urandom_range(0, 12)), 10'($urandom)};
            endcase
            i_a = ra;
            i_b = rb;
            @(posedge clk); #1;
            check_rand(ra, rb, o_res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
